// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a ripple of full_adder cells,
// with the inter-digit carry held in a register. Start/done handshake, flags valid from done.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] da_s, db_s, ds_s;
  logic             msb_cin_s, chain_cout_s;

  // Pick the operand digit addressed by the counter.
  always_comb begin
    da_s = {DIGIT{1'b0}};
    db_s = {DIGIT{1'b0}};
    for (int i = 0; i < N; i++) begin
      da_s = (cnt_q == CW'(i)) ? a_q[i*DIGIT +: DIGIT] : da_s;
      db_s = (cnt_q == CW'(i)) ? b_q[i*DIGIT +: DIGIT] : db_s;
    end
  end

  // Per-stage carry nets keep the ripple free of a self-referencing vector.
  for (genvar g = 0; g < DIGIT; g++) begin : g_chain
    logic ci_s;
    logic co_s;
    if (g == 0) begin : g_first
      assign ci_s = carry_q;
    end else begin : g_next
      assign ci_s = g_chain[g-1].co_s;
    end
    full_adder u_fa (
      .a_i (da_s[g]),
      .b_i (db_s[g]),
      .c_i (ci_s),
      .s_o (ds_s[g]),
      .c_o (co_s)
    );
  end

  assign msb_cin_s    = g_chain[DIGIT-1].ci_s;
  assign chain_cout_s = g_chain[DIGIT-1].co_s;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction runs as A + ~B + ~borrow, i.e. A - B - carry_in.
          a_d     = input1;
          b_d     = mode ? ~input2 : input2;
          carry_d = mode ^ carry_in;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          sum_d[i*DIGIT +: DIGIT] = (cnt_q == CW'(i)) ? ds_s : sum_q[i*DIGIT +: DIGIT];
        end
        carry_d = chain_cout_s;
        if (cnt_q == LAST) begin
          cnt_d   = {CW{1'b0}};
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = chain_cout_s;
          ovf_d   = msb_cin_s ^ chain_cout_s;
          zero_d  = (sum_d == {WIDTH{1'b0}});
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: three configurations (8/1, 16/4, 16/16) checked every cycle
// against an arithmetic reference, plus directed corner cases with literal results.
module tb_serial_add_sub;
  localparam int WS [3] = '{8, 16, 16};
  localparam int NS [3] = '{8, 4, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st  [3] = '{1'b0, 1'b0, 1'b0};
  logic        md  [3] = '{1'b0, 1'b0, 1'b0};
  logic        ci  [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] a   [3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] b   [3] = '{16'h0, 16'h0, 16'h0};

  logic        busy_w [3];
  logic        done_w [3];
  logic        cout_w [3];
  logic        ovf_w  [3];
  logic        zero_w [3];
  logic [7:0]  sum8;
  logic [15:0] sum16a, sum16b;
  logic [15:0] sum_w  [3];

  assign sum_w[0] = {8'h00, sum8};
  assign sum_w[1] = sum16a;
  assign sum_w[2] = sum16b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;

  // model state: remaining digit cycles, result validity, expected {zero,ovf,cout,sum}
  int          m_rem   [3] = '{0, 0, 0};
  logic        m_fin   [3] = '{1'b0, 1'b0, 1'b0};
  logic        m_valid [3] = '{1'b0, 1'b0, 1'b0};
  logic [18:0] m_exp   [3];
  logic [18:0] m_pend  [3];

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_w8 (
    .clock(clk), .reset(rst), .start(st[0]), .mode(md[0]),
    .input1(a[0][7:0]), .input2(b[0][7:0]), .carry_in(ci[0]),
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum8),
    .carry_out(cout_w[0]), .overflow(ovf_w[0]), .zero(zero_w[0]));

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clock(clk), .reset(rst), .start(st[1]), .mode(md[1]),
    .input1(a[1]), .input2(b[1]), .carry_in(ci[1]),
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum16a),
    .carry_out(cout_w[1]), .overflow(ovf_w[1]), .zero(zero_w[1]));

  serial_add_sub #(.WIDTH(16), .DIGIT(16)) u_w16d16 (
    .clock(clk), .reset(rst), .start(st[2]), .mode(md[2]),
    .input1(a[2]), .input2(b[2]), .carry_in(ci[2]),
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum16b),
    .carry_out(cout_w[2]), .overflow(ovf_w[2]), .zero(zero_w[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference result from plain integer arithmetic: {zero, overflow, carry_out, sum}.
  function automatic logic [18:0] model(input int w, input logic sub, input logic [15:0] x,
                                        input logic [15:0] y, input logic cin);
    longint half, mask, ux, uy, full, sx, sy, r;
    logic [18:0] res;
    half = longint'(1) << (w - 1);
    mask = (half << 1) - 1;
    ux   = longint'(x) & mask;
    uy   = longint'(y) & mask;
    full = sub ? ux - uy - longint'(cin) : ux + uy + longint'(cin);
    sx   = (ux >= half) ? ux - 2 * half : ux;
    sy   = (uy >= half) ? uy - 2 * half : uy;
    r    = sub ? sx - sy - longint'(cin) : sx + sy + longint'(cin);
    res[15:0] = 16'(full & mask);
    res[16]   = sub ? (full >= 0) : (full > mask);
    res[17]   = (r >= half) || (r < -half);
    res[18]   = ((full & mask) == 0);
    return res;
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h at cycle %0d", name, inst, act, exp, cyc);
    end
  endtask

  // Behavioural timing model: an accepted start yields done N edges later.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m_fin[i] <= 1'b0;
      if (rst) begin
        m_rem[i]   <= 0;
        m_valid[i] <= 1'b1;
        m_exp[i]   <= 19'h0;
      end else if (m_rem[i] == 0) begin
        if (st[i]) begin
          m_rem[i]   <= NS[i];
          m_valid[i] <= 1'b0;
          m_pend[i]  <= model(WS[i], md[i], a[i], b[i], ci[i]);
        end
      end else begin
        m_rem[i] <= m_rem[i] - 1;
        if (m_rem[i] == 1) begin
          m_fin[i]   <= 1'b1;
          m_valid[i] <= 1'b1;
          m_exp[i]   <= m_pend[i];
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("busy", i, 32'(busy_w[i]), 32'(m_rem[i] != 0));
      chk("done", i, 32'(done_w[i]), 32'(m_fin[i]));
      if (m_valid[i]) begin
        chk("result", i, 32'({zero_w[i], ovf_w[i], cout_w[i], sum_w[i]}), 32'(m_exp[i]));
      end
    end
  end

  task automatic start_op(input int i, input logic m, input logic [15:0] x, input logic [15:0] y,
                          input logic c);
    md[i] = m; a[i] = x; b[i] = y; ci[i] = c; st[i] = 1'b1;
    @(posedge clk); #1;
    st[i] = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int i, input int lat, input logic [18:0] exp);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = done_w[i];
    end
    chk("done_timeout", i, 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", i, 32'(cyc - start_cyc), 32'(lat));
      chk("lit_result", i, 32'({zero_w[i], ovf_w[i], cout_w[i], sum_w[i]}), 32'(exp));
    end
  endtask

  localparam logic [15:0] CORNER [6] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0080, 16'h007F};

  initial begin
    // pin the reference model itself
    chk("model_add", 0, 32'(model(8, 1'b0, 16'd100, 16'd27, 1'b0)), 32'h0007F);
    chk("model_sub", 0, 32'(model(8, 1'b1, 16'd5, 16'd7, 1'b0)), 32'h000FE);
    chk("model_ovf", 0, 32'(model(8, 1'b1, 16'h80, 16'h01, 1'b0)), 32'h3007F);
    chk("model_w16", 1, 32'(model(16, 1'b0, 16'hFFFF, 16'h0001, 1'b0)), 32'h50000);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("reset_res", 0, 32'({zero_w[0], ovf_w[0], cout_w[0], sum_w[0]}), 32'd0);

    // expected literal packing: {zero, overflow, carry_out, sum}
    start_op(0, 1'b0, 16'd100, 16'd27, 1'b0);  wait_done(0, 8, 19'h0007F);
    start_op(0, 1'b0, 16'h7F, 16'h01, 1'b0);   wait_done(0, 8, 19'h20080);
    start_op(0, 1'b0, 16'hFF, 16'h01, 1'b0);   wait_done(0, 8, 19'h50000);
    start_op(0, 1'b1, 16'd5, 16'd7, 1'b0);     wait_done(0, 8, 19'h000FE);
    start_op(0, 1'b1, 16'h80, 16'h01, 1'b0);   wait_done(0, 8, 19'h3007F);
    start_op(0, 1'b1, 16'd9, 16'd4, 1'b1);     wait_done(0, 8, 19'h10004);

    // start during RUN is ignored; then a start held into DONE launches immediately
    start_op(0, 1'b0, 16'd10, 16'd20, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    md[0] = 1'b1; a[0] = 16'hAA; b[0] = 16'h11; ci[0] = 1'b1; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    wait_done(0, 8, 19'h0001E);
    start_op(0, 1'b0, 16'd3, 16'd4, 1'b0);
    @(negedge clk);
    chk("b2b_busy", 0, 32'(busy_w[0]), 32'd1);
    wait_done(0, 8, 19'h00007);

    // reset mid-RUN aborts with no done pulse
    start_op(0, 1'b0, 16'h12, 16'h34, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("abort_done", 0, 32'(done_w[0]), 32'd0);
    chk("abort_res", 0, 32'({zero_w[0], ovf_w[0], cout_w[0], sum_w[0]}), 32'd0);
    start_op(0, 1'b0, 16'h12, 16'h34, 1'b0);   wait_done(0, 8, 19'h00046);

    start_op(1, 1'b0, 16'hFFFF, 16'h0001, 1'b0); wait_done(1, 4, 19'h50000);
    start_op(2, 1'b0, 16'hFFFF, 16'h0001, 1'b0); wait_done(2, 1, 19'h50000);
    start_op(1, 1'b1, 16'h8000, 16'h0001, 1'b0); wait_done(1, 4, 19'h37FFF);

    // randomized traffic, including starts during RUN, changing inputs and rare resets
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        st[i] = ($urandom_range(0, 2) == 0);
        md[i] = 1'($urandom_range(0, 1));
        ci[i] = 1'($urandom_range(0, 1));
        a[i]  = ($urandom_range(0, 3) == 0) ? CORNER[$urandom_range(0, 5)] : 16'($urandom);
        b[i]  = ($urandom_range(0, 3) == 0) ? CORNER[$urandom_range(0, 5)] : 16'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
